// File: rtl/free_ptr_pool_pkg.sv
// Shared hash-table definitions used by the free-pointer pool.
package free_ptr_pool_pkg;

    // Width of a data-table address.
    localparam int TABLE_ADDR_WIDTH = 3;

    // Even-parity bit of a data-table address, for consumers that protect
    // pointers in flight.
    function automatic logic addr_parity(input logic [TABLE_ADDR_WIDTH-1:0] addr);
        return ^addr;
    endfunction

endpackage

// File: rtl/free_ptr_pool.sv
// Free-pointer pool for the data table: a circular list of unused addresses
// with a membership bitmap so that duplicate returns can be rejected. After
// reset it loads every address 0..DEPTH-1 before it reports ready.
module free_ptr_pool
    import free_ptr_pool_pkg::*;
#(
    parameter int A_WIDTH = TABLE_ADDR_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [A_WIDTH-1:0] add_empty_ptr_i,
    input  logic               add_empty_ptr_en_i,
    output logic [A_WIDTH-1:0] next_empty_ptr_o,
    output logic               next_empty_ptr_val_o,
    input  logic               next_empty_ptr_rd_ack_i,
    output logic               init_done_o,
    output logic [A_WIDTH:0]   count_o,
    output logic               dup_add_err_o,
    output logic               add_in_init_err_o
);

    localparam int DEPTH = 2 ** A_WIDTH;

    typedef enum logic [0:0] {
        INIT_S  = 1'b0,
        READY_S = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [A_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]   r_in_pool;
    logic [DEPTH-1:0]   w_in_pool_nxt;
    logic [A_WIDTH-1:0] r_rd_ptr;
    logic [A_WIDTH-1:0] r_wr_ptr;
    logic [A_WIDTH-1:0] r_init_cnt;
    logic [A_WIDTH:0]   r_count;
    logic               r_dup_err;
    logic               r_init_err;

    logic [A_WIDTH-1:0] w_head;
    logic               w_ready;
    logic               w_last_init;
    logic               w_pop;
    logic               w_push;
    logic               w_dup;
    logic               w_init_err;

    // Decode pop/push legality, bitmap update and next state.
    always_comb begin
        w_head        = r_mem[r_rd_ptr];
        w_ready       = (r_state == READY_S);
        w_last_init   = (r_state == INIT_S) && (r_init_cnt == A_WIDTH'(DEPTH - 1));
        w_pop         = w_ready && (r_count != (A_WIDTH + 1)'(0)) && next_empty_ptr_rd_ack_i;
        // An address leaving the pool this cycle may legally come straight back.
        w_push        = add_empty_ptr_en_i && w_ready &&
                        (!r_in_pool[add_empty_ptr_i] || (w_pop && (w_head == add_empty_ptr_i)));
        w_dup         = add_empty_ptr_en_i && w_ready && !w_push;
        w_init_err    = add_empty_ptr_en_i && !w_ready;
        w_in_pool_nxt = r_in_pool;
        w_state_nxt   = r_state;
        if (r_state == INIT_S) begin
            w_in_pool_nxt[r_init_cnt] = 1'b1;
        end else begin
            if (w_pop) begin
                w_in_pool_nxt[w_head] = 1'b0;
            end else begin
                w_in_pool_nxt = w_in_pool_nxt;
            end
            if (w_push) begin
                w_in_pool_nxt[add_empty_ptr_i] = 1'b1;
            end else begin
                w_in_pool_nxt = w_in_pool_nxt;
            end
        end
        case (r_state)
            INIT_S:  w_state_nxt = w_last_init ? READY_S : INIT_S;
            READY_S: w_state_nxt = READY_S;
            default: w_state_nxt = INIT_S;
        endcase
    end

    // Storage array: identity fill during init, returned addresses afterwards.
    always_ff @(posedge clk_i) begin
        if (r_state == INIT_S) begin
            r_mem[r_init_cnt] <= r_init_cnt;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= add_empty_ptr_i;
        end
    end

    // State, pointers, count, bitmap and error pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= INIT_S;
            r_in_pool  <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_init_cnt <= '0;
            r_count    <= '0;
            r_dup_err  <= 1'b0;
            r_init_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_pool  <= w_in_pool_nxt;
            r_dup_err  <= w_dup;
            r_init_err <= w_init_err;
            if (r_state == INIT_S) begin
                r_init_cnt <= r_init_cnt + A_WIDTH'(1);
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= w_last_init ? (A_WIDTH + 1)'(DEPTH) : (A_WIDTH + 1)'(0);
            end else begin
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + A_WIDTH'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + A_WIDTH'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (A_WIDTH + 1)'(1);
                    2'b01:   r_count <= r_count - (A_WIDTH + 1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign next_empty_ptr_o     = w_ready ? w_head : {A_WIDTH{1'b0}};
    assign next_empty_ptr_val_o = w_ready && (r_count != (A_WIDTH + 1)'(0));
    assign init_done_o          = w_ready;
    assign count_o              = r_count;
    assign dup_add_err_o        = r_dup_err;
    assign add_in_init_err_o    = r_init_err;

endmodule

// File: tb/tb_free_ptr_pool.sv
// Directed bench for free_ptr_pool with A_WIDTH = 3 (DEPTH = 8).
module tb_free_ptr_pool;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [2:0] add_empty_ptr_i;
    logic       add_empty_ptr_en_i;
    logic [2:0] next_empty_ptr_o;
    logic       next_empty_ptr_val_o;
    logic       next_empty_ptr_rd_ack_i;
    logic       init_done_o;
    logic [3:0] count_o;
    logic       dup_add_err_o;
    logic       add_in_init_err_o;

    int n_total = 0;
    int n_pass  = 0;

    free_ptr_pool #(.A_WIDTH(3)) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .add_empty_ptr_i         (add_empty_ptr_i),
        .add_empty_ptr_en_i      (add_empty_ptr_en_i),
        .next_empty_ptr_o        (next_empty_ptr_o),
        .next_empty_ptr_val_o    (next_empty_ptr_val_o),
        .next_empty_ptr_rd_ack_i (next_empty_ptr_rd_ack_i),
        .init_done_o             (init_done_o),
        .count_o                 (count_o),
        .dup_add_err_o           (dup_add_err_o),
        .add_in_init_err_o       (add_in_init_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic push(input logic [2:0] a);
        add_empty_ptr_i    = a;
        add_empty_ptr_en_i = 1'b1;
        step();
        add_empty_ptr_en_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        add_empty_ptr_i = 3'd0;
        add_empty_ptr_en_i = 1'b0;
        next_empty_ptr_rd_ack_i = 1'b0;
        step();
        chk("rst_init_done", init_done_o, 0);
        chk("rst_val", next_empty_ptr_val_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_ptr", next_empty_ptr_o, 0);
        rst_i = 1'b0;

        // Init takes exactly 8 cycles.
        for (int i = 0; i < 7; i++) step();
        chk("init_not_done_7", init_done_o, 0);
        step();
        chk("init_done_8", init_done_o, 1);
        chk("init_val", next_empty_ptr_val_o, 1);
        chk("init_head", next_empty_ptr_o, 0);
        chk("init_count", count_o, 8);

        // Push while full is a duplicate.
        push(3'd3);
        chk("full_dup_pulse", dup_add_err_o, 1);
        chk("full_dup_count", count_o, 8);
        step();
        chk("full_dup_clear", dup_add_err_o, 0);

        // Drain with 10 acks; last two are ignored.
        next_empty_ptr_rd_ack_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                chk("drain_val", next_empty_ptr_val_o, 1);
                chk("drain_head", next_empty_ptr_o, i);
            end else begin
                chk("drain_empty_val", next_empty_ptr_val_o, 0);
            end
            step();
            chk("drain_count", count_o, (i < 8) ? 7 - i : 0);
            chk("drain_no_err", dup_add_err_o, 0);
        end
        next_empty_ptr_rd_ack_i = 1'b0;
        chk("empty_val", next_empty_ptr_val_o, 0);

        // Refill when empty.
        push(3'd5);
        chk("refill_val", next_empty_ptr_val_o, 1);
        chk("refill_head", next_empty_ptr_o, 5);
        chk("refill_count", count_o, 1);

        // Duplicate of held address.
        push(3'd5);
        chk("dup_pulse", dup_add_err_o, 1);
        chk("dup_count", count_o, 1);
        step();
        chk("dup_single_cycle", dup_add_err_o, 0);

        // Simultaneous ack of 5 with push of 4.
        next_empty_ptr_rd_ack_i = 1'b1;
        push(3'd4);
        next_empty_ptr_rd_ack_i = 1'b0;
        chk("sim_head", next_empty_ptr_o, 4);
        chk("sim_val", next_empty_ptr_val_o, 1);
        chk("sim_count", count_o, 1);
        chk("sim_no_err", dup_add_err_o, 0);

        // Ack 4 + push 5, then ack 5 + push 5 (same address returns).
        next_empty_ptr_rd_ack_i = 1'b1;
        push(3'd5);
        chk("sim2_head", next_empty_ptr_o, 5);
        push(3'd5);
        next_empty_ptr_rd_ack_i = 1'b0;
        chk("same_addr_no_err", dup_add_err_o, 0);
        chk("same_addr_head", next_empty_ptr_o, 5);
        chk("same_addr_count", count_o, 1);

        // FIFO order 5, 2, 7.
        push(3'd2);
        push(3'd7);
        chk("fifo_count", count_o, 3);
        next_empty_ptr_rd_ack_i = 1'b1;
        chk("fifo_0", next_empty_ptr_o, 5);
        step();
        chk("fifo_1", next_empty_ptr_o, 2);
        step();
        chk("fifo_2", next_empty_ptr_o, 7);
        step();
        next_empty_ptr_rd_ack_i = 1'b0;
        chk("fifo_empty_val", next_empty_ptr_val_o, 0);
        chk("fifo_empty_count", count_o, 0);

        // Reset mid-operation after three pops.
        push(3'd1);
        push(3'd6);
        push(3'd0);
        next_empty_ptr_rd_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) step();
        next_empty_ptr_rd_ack_i = 1'b0;
        chk("pre_rst_count", count_o, 0);
        push(3'd6);
        chk("pre_rst_count2", count_o, 1);
        rst_i = 1'b1;
        #1;
        chk("midrst_init_done", init_done_o, 0);
        chk("midrst_count", count_o, 0);
        chk("midrst_val", next_empty_ptr_val_o, 0);
        step();
        rst_i = 1'b0;

        // Push during init is rejected.
        push(3'd3);
        chk("init_err_pulse", add_in_init_err_o, 1);
        step();
        chk("init_err_clear", add_in_init_err_o, 0);
        for (int i = 0; i < 5; i++) step();
        chk("reinit_not_done", init_done_o, 0);
        step();
        chk("reinit_done", init_done_o, 1);
        chk("reinit_count", count_o, 8);
        chk("reinit_head", next_empty_ptr_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/free_ptr_pool.md
Name: free_ptr_pool

Overview:
Free-pointer pool for the data table; the receiving end of the add_empty_ptr / add_empty_ptr_en interface driven by data_table_delete.
- Holds every data-table address not currently linked into a bucket chain.
- Presents one free address at a time, show-ahead style, to the insert logic, which consumes it with an acknowledge.
- After reset, fills itself with all DEPTH addresses before it declares itself ready.

Parameters:
A_WIDTH, TABLE_ADDR_WIDTH, width of a data-table address.
DEPTH, 2**A_WIDTH, number of pool entries. Fixed; not overridden independently.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
add_empty_ptr_i  in  A_WIDTH  address being returned to the pool
add_empty_ptr_en_i  in  1  return strobe, one address per cycle
next_empty_ptr_o  out  A_WIDTH  current head free address (show-ahead)
next_empty_ptr_val_o  out  1  next_empty_ptr_o is valid
next_empty_ptr_rd_ack_i  in  1  consumer took next_empty_ptr_o this cycle
init_done_o  out  1  initial fill complete
count_o  out  A_WIDTH+1  number of addresses in pool, 0..DEPTH
dup_add_err_o  out  1  one-cycle pulse: returned address was already in pool, dropped
add_in_init_err_o  out  1  one-cycle pulse: return strobe during INIT_S, dropped

Behaviour:
Reset values (async, while rst_i high):
- All outputs 0.
- rd_ptr = 0, wr_ptr = 0, count = 0, in_pool bitmap all 0, state = INIT_S, init counter = 0.

Storage:
- DEPTH x A_WIDTH circular array with write pointer wr_ptr and read pointer rd_ptr, each A_WIDTH bits, wrapping modulo DEPTH.
- in_pool is a DEPTH-bit membership bitmap.

States:
- INIT_S: one write per cycle, mem[i] = i and in_pool[i] = 1, for i = 0..DEPTH-1. On the cycle writing DEPTH-1, go to READY_S with wr_ptr = 0 (wrapped), rd_ptr = 0, count = DEPTH. Takes exactly DEPTH cycles after reset release; init_done_o rises on the first READY_S cycle.
- READY_S: normal operation; never leaves except on reset.

Outputs in READY_S:
- next_empty_ptr_o = mem[rd_ptr], combinational from state.
- next_empty_ptr_val_o = (count != 0).
- next_empty_ptr_o is don't-care when val = 0.

Acknowledge (pop):
- Effective only if next_empty_ptr_val_o = 1; otherwise ignored, with no state change and no error.
- On pop: rd_ptr++, count--, in_pool[mem[rd_ptr]] cleared.

Return (push):
- Legal if in READY_S and the address is not in the pool. An address that is being popped in the same cycle counts as not in the pool.
- On legal push: mem[wr_ptr] = add_empty_ptr_i, wr_ptr++, count++, in_pool set.
- Address already in pool: dropped, dup_add_err_o pulses the next cycle. A full pool (count = DEPTH) makes every push a duplicate, so overflow is impossible.
- Push during INIT_S: dropped, add_in_init_err_o pulses the next cycle.

Simultaneous pop and push:
- Both take effect and count is unchanged.
- With count = 1, the pushed address becomes the head next cycle and val stays 1.

Timing and counts:
- A pushed address is visible on next_empty_ptr_o one cycle later when the pool was empty.
- count_o reflects a push or pop one cycle after the strobe.
- count_o never exceeds DEPTH and never wraps below 0.

Other rules:
- Reset asserted mid-operation discards all contents and restarts INIT_S; the pool contents restart from 0..DEPTH-1.
- Error pulses are single-cycle and not sticky.

Decomposition:
- hash_table package: reuse TABLE_ADDR_WIDTH; add the free_ptr_pool state enum typedef (INIT_S, READY_S) only if other blocks reference it, otherwise keep it local.
- No sub-module required. The storage array and bitmap stay inline so that synthesis can infer distributed RAM; a separate memory wrapper is not justified at this size.

Test Plan:
- Init, A_WIDTH = 3: release reset, hold all inputs 0 -> init_done_o rises after exactly 8 cycles; val = 1, next_empty_ptr_o = 0, count_o = 8.
- Drain: ack every cycle for 10 cycles after init -> pointers 0,1,..,7 observed, then val = 0 and count_o = 0; the extra 2 acks cause no error and no count change.
- Refill when empty: push 5 -> next cycle val = 1, next_empty_ptr_o = 5, count_o = 1. Then push 2 and push 7 -> pops return 5, 2, 7 in FIFO order.
- Duplicate return: pool holds {5}, push 5 -> dup_add_err_o = 1 for one cycle, count_o stays 1. Push 3 while count = 8 after init -> dup_add_err_o pulse, count_o stays 8.
- Simultaneous: count = 1, head 5, same cycle ack + push 4 -> next cycle next_empty_ptr_o = 4, val = 1, count_o = 1. Also ack of 5 + push of 5 in the same cycle -> accepted, no error.
- Reset mid-op: after 3 pops, assert rst_i for 1 cycle -> outputs 0 immediately. Push during the following 8 init cycles -> add_in_init_err_o pulse. After init: count_o = 8, head = 0.
